pixel_frame_loader: RTL

- Input-side counterpart to the dark-channel enhancement core.
- Accepts a serial RGB pixel stream with a valid/ready handshake and writes each frame into a double-buffered 8x8 frame store.
- Tells the core when a full frame is available and serves the core's random per-pixel reads with 1-cycle latency.
- One bank fills while the core consumes the other; the core hands a bank back with a release pulse.

---
 rtl/pixel_pkg.sv | 22 ++
 rtl/frame_bank_ram.sv | 71 +++++++
 rtl/pixel_frame_loader.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pixel_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_pkg
//  Purpose  : Shared constants and pixel type for the pixel frame loader.
//  Revision : 1.0 - initial release
// ============================================================================
package pixel_pkg;

   localparam int IMG_W  = 8;
   localparam int IMG_H  = 8;
   localparam int PIX_W  = 8;
   localparam int ADDR_W = 6;
   localparam int NPIX   = IMG_W * IMG_H;

   typedef struct packed {
      logic [PIX_W-1:0] r;
      logic [PIX_W-1:0] g;
      logic [PIX_W-1:0] b;
   } rgb_t;

endpackage : pixel_pkg
`default_nettype wire

// File: rtl/frame_bank_ram.sv
`default_nettype none
// ============================================================================
//  Module   : frame_bank_ram
//  Purpose  : One frame bank. Three channel arrays with synchronous write and
//             a registered read port; out-of-range reads return zero.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_bank_ram
   import pixel_pkg::*;
#(
   parameter int DATA_W = PIX_W,
   parameter int AW     = ADDR_W,
   parameter int DEPTH  = NPIX
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en_i,
   input  logic [AW-1:0]     wr_addr_i,
   input  logic [DATA_W-1:0] wr_r_i,
   input  logic [DATA_W-1:0] wr_g_i,
   input  logic [DATA_W-1:0] wr_b_i,
   input  logic [AW-1:0]     rd_addr_i,
   output logic [DATA_W-1:0] rd_r_o,
   output logic [DATA_W-1:0] rd_g_o,
   output logic [DATA_W-1:0] rd_b_o
);

   logic [DATA_W-1:0] mem_r_q [DEPTH];
   logic [DATA_W-1:0] mem_g_q [DEPTH];
   logic [DATA_W-1:0] mem_b_q [DEPTH];

   logic [DATA_W-1:0] rd_r_q;
   logic [DATA_W-1:0] rd_g_q;
   logic [DATA_W-1:0] rd_b_q;

   logic              rd_in_range_w;

   assign rd_in_range_w = (32'(rd_addr_i) < 32'(DEPTH));

   // Storage write; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_r_q[wr_addr_i] <= wr_r_i;
         mem_g_q[wr_addr_i] <= wr_g_i;
         mem_b_q[wr_addr_i] <= wr_b_i;
      end
   end

   // Registered read port, zero for addresses beyond the frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_r_q <= '0;
         rd_g_q <= '0;
         rd_b_q <= '0;
      end else if (rd_in_range_w) begin
         rd_r_q <= mem_r_q[rd_addr_i];
         rd_g_q <= mem_g_q[rd_addr_i];
         rd_b_q <= mem_b_q[rd_addr_i];
      end else begin
         rd_r_q <= '0;
         rd_g_q <= '0;
         rd_b_q <= '0;
      end
   end

   assign rd_r_o = rd_r_q;
   assign rd_g_o = rd_g_q;
   assign rd_b_o = rd_b_q;

endmodule : frame_bank_ram
`default_nettype wire

// File: rtl/pixel_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_frame_loader
//  Purpose  : Loads a valid/ready RGB pixel stream into a double-buffered
//             frame store, flags complete frames to the enhancement core and
//             serves its per-pixel reads with one cycle of latency.
//  Revision : 1.0 - initial release
// ============================================================================
module pixel_frame_loader
   import pixel_pkg::*;
#(
   parameter int IMG_W  = pixel_pkg::IMG_W,
   parameter int IMG_H  = pixel_pkg::IMG_H,
   parameter int PIX_W  = pixel_pkg::PIX_W,
   parameter int ADDR_W = pixel_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sof,
   input  logic [PIX_W-1:0]  in_R,
   input  logic [PIX_W-1:0]  in_G,
   input  logic [PIX_W-1:0]  in_B,
   output logic              frame_ready,
   input  logic              frame_release,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [PIX_W-1:0]  rd_R,
   output logic [PIX_W-1:0]  rd_G,
   output logic [PIX_W-1:0]  rd_B,
   output logic              sof_err,
   output logic [7:0]        frame_count
);

   localparam int                FRAME_PIX = IMG_W * IMG_H;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);

   // Bank control state
   logic              wr_bank_q,     wr_bank_d;
   logic              rd_bank_q,     rd_bank_d;
   logic [1:0]        bank_full_q,   bank_full_d;
   logic [ADDR_W-1:0] wr_ptr_q,      wr_ptr_d;
   logic [7:0]        frame_count_q, frame_count_d;
   logic              sof_err_q,     sof_err_d;
   logic              frame_ready_q;
   logic              rd_sel_q;

   logic              accept_w;
   logic              release_w;
   logic              last_beat_w;
   logic [ADDR_W-1:0] wr_addr_w;
   logic [1:0]        bank_we_w;

   logic [PIX_W-1:0]  bank_r_w [2];
   logic [PIX_W-1:0]  bank_g_w [2];
   logic [PIX_W-1:0]  bank_b_w [2];

   assign in_ready    = !rst && !bank_full_q[wr_bank_q];
   assign accept_w    = in_valid && in_ready;
   assign release_w   = frame_release && frame_ready_q;
   // An SOF beat always restarts at address 0, so it can never close a frame.
   assign last_beat_w = !in_sof && (wr_ptr_q == LAST_ADDR);
   assign wr_addr_w   = in_sof ? '0 : wr_ptr_q;
   assign bank_we_w   = accept_w ? (wr_bank_q ? 2'b10 : 2'b01) : 2'b00;

   // Next-state for write pointer, bank ownership and counters.
   always_comb begin
      wr_bank_d     = wr_bank_q;
      rd_bank_d     = rd_bank_q;
      bank_full_d   = bank_full_q;
      wr_ptr_d      = wr_ptr_q;
      frame_count_d = frame_count_q;
      sof_err_d     = 1'b0;

      if (accept_w) begin
         if (in_sof) begin
            wr_ptr_d  = ADDR_W'(1);
            sof_err_d = (wr_ptr_q != '0);
         end else if (last_beat_w) begin
            bank_full_d[wr_bank_q] = 1'b1;
            wr_bank_d              = ~wr_bank_q;
            wr_ptr_d               = '0;
            frame_count_d          = frame_count_q + 8'd1;
         end else begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
         end
      end

      // A release targets the bank being read, which is full and therefore
      // never the bank completing this cycle, so both updates can coexist.
      if (release_w) begin
         bank_full_d[rd_bank_q] = 1'b0;
         rd_bank_d              = ~rd_bank_q;
      end
   end

   // Control registers; frame_ready tracks the next-state so it rises with the
   // cycle following the closing beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_bank_q     <= 1'b0;
         rd_bank_q     <= 1'b0;
         bank_full_q   <= 2'b00;
         wr_ptr_q      <= '0;
         frame_count_q <= 8'd0;
         sof_err_q     <= 1'b0;
         frame_ready_q <= 1'b0;
         rd_sel_q      <= 1'b0;
      end else begin
         wr_bank_q     <= wr_bank_d;
         rd_bank_q     <= rd_bank_d;
         bank_full_q   <= bank_full_d;
         wr_ptr_q      <= wr_ptr_d;
         frame_count_q <= frame_count_d;
         sof_err_q     <= sof_err_d;
         frame_ready_q <= bank_full_d[rd_bank_d];
         rd_sel_q      <= rd_bank_q;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      frame_bank_ram #(
         .DATA_W (PIX_W),
         .AW     (ADDR_W),
         .DEPTH  (FRAME_PIX)
      ) u_bank (
         .clk       (clk),
         .rst       (rst),
         .wr_en_i   (bank_we_w[b]),
         .wr_addr_i (wr_addr_w),
         .wr_r_i    (in_R),
         .wr_g_i    (in_G),
         .wr_b_i    (in_B),
         .rd_addr_i (rd_addr),
         .rd_r_o    (bank_r_w[b]),
         .rd_g_o    (bank_g_w[b]),
         .rd_b_o    (bank_b_w[b])
      );
   end

   // Both banks read every cycle; the bank that was the read bank when the
   // address was presented selects the result.
   assign rd_R = rd_sel_q ? bank_r_w[1] : bank_r_w[0];
   assign rd_G = rd_sel_q ? bank_g_w[1] : bank_g_w[0];
   assign rd_B = rd_sel_q ? bank_b_w[1] : bank_b_w[0];

   assign frame_ready = frame_ready_q;
   assign sof_err     = sof_err_q;
   assign frame_count = frame_count_q;

endmodule : pixel_frame_loader
`default_nettype wire
